// File: rtl/cost_table_pkg.sv
// Shared types and sizes for the JAM cost table: widths, FSM states and index helper.
package jam_pkg;

  localparam int unsigned N_WORKER = 8;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned COST_W   = 7;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned CHK_W    = 13;
  localparam int unsigned N_ENTRY  = N_WORKER * N_WORKER;

  typedef enum logic {
    LOAD  = 1'b0,
    READY = 1'b1
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0] w;
    logic [SEL_W-1:0] j;
  } cost_addr_t;

  // Row-major flattening: idx = 8*W + J.
  function automatic logic [IDX_W-1:0] to_idx(input cost_addr_t a);
    return IDX_W'({a.w, a.j});
  endfunction

endpackage

// File: rtl/cost_table_if.sv
// Load stream and lookup bus of the cost table; Checksum exists only with COST_CHECKSUM_EN.
interface cost_table_if;
  import jam_pkg::*;

  logic                 LoadValid;
  logic [COST_W-1:0]    LoadData;
  logic                 LoadReady;
  logic                 Reload;
  logic [SEL_W-1:0]     W;
  logic [SEL_W-1:0]     J;
  logic [COST_W-1:0]    Cost;
  logic                 TableReady;
  logic                 JamRST;
`ifdef COST_CHECKSUM_EN
  logic [CHK_W-1:0]     Checksum;
`endif

  modport master (
    output LoadValid, LoadData, Reload, W, J,
    input  LoadReady, Cost, TableReady, JamRST
`ifdef COST_CHECKSUM_EN
    , input Checksum
`endif
  );

  modport slave (
    input  LoadValid, LoadData, Reload, W, J,
    output LoadReady, Cost, TableReady, JamRST
`ifdef COST_CHECKSUM_EN
    , output Checksum
`endif
  );

endinterface

// File: rtl/cost_table_rf.sv
// 64x7 cost register file: synchronous write and clear, asynchronous read (old data on collision).
module cost_rf
  import jam_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [COST_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [COST_W-1:0] rdata
);

  logic [N_ENTRY-1:0][COST_W-1:0] mem_q;
  logic [N_ENTRY-1:0][COST_W-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cost_table.sv
// JAM cost table: streams 64 row-major costs into cost_rf and holds the JAM engine in reset until complete.
// Optional running checksum of accepted entries when COST_CHECKSUM_EN is defined.
module cost_table
  import jam_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  cost_table_if.slave  bus
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             jam_rst_q, jam_rst_d;
  logic             accept_c;
  cost_addr_t       rd_addr_c;

  // Reload dominates everything, including the final acceptance at idx 63.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    jam_rst_d = jam_rst_q;
    accept_c  = (state_q == LOAD) && bus.LoadValid && !bus.Reload;
    if (bus.Reload) begin
      state_d   = LOAD;
      idx_d     = '0;
      jam_rst_d = 1'b1;
    end else begin
      jam_rst_d = (state_q == LOAD);
      if (accept_c) begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N_ENTRY - 1)) state_d = READY;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= LOAD;
      idx_q     <= '0;
      jam_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      jam_rst_q <= jam_rst_d;
    end
  end

  assign bus.LoadReady  = (state_q == LOAD);
  assign bus.TableReady = (state_q == READY);
  assign bus.JamRST     = jam_rst_q;
  assign rd_addr_c      = {bus.W, bus.J};

  cost_rf u_rf (
    .clk   (CLK),
    .rst   (RST),
    .we    (accept_c),
    .waddr (idx_q),
    .wdata (bus.LoadData),
    .raddr (to_idx(rd_addr_c)),
    .rdata (bus.Cost)
  );

`ifdef COST_CHECKSUM_EN
  logic [CHK_W-1:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (bus.Reload)    chk_d = '0;
    else if (accept_c) chk_d = chk_q + CHK_W'(bus.LoadData);
  end

  always_ff @(posedge CLK) begin
    if (RST) chk_q <= '0;
    else     chk_q <= chk_d;
  end

  assign bus.Checksum = chk_q;
`endif

endmodule

// File: tb/tb_cost_table.sv
// Directed bench for cost_table: load, gapped load, READY ignore, Reload cases, reset priority.
module tb_cost_table;
  import jam_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  cost_table_if bus();

  cost_table dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic peek(input string tag, input int w, input int j, input int exp);
    bus.W = SEL_W'(w);
    bus.J = SEL_W'(j);
    #1;
    chk(tag, 32'(bus.Cost), 32'(exp));
  endtask

  task automatic chk_sum(input string tag, input int exp);
`ifdef COST_CHECKSUM_EN
    chk(tag, 32'(bus.Checksum), 32'(exp));
`else
    if (exp < 0) $display("unused %s", tag);
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.LoadValid = 1'b0;
    bus.LoadData  = '0;
    bus.Reload    = 1'b0;
    bus.W = '0;
    bus.J = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_load_ready", 32'(bus.LoadReady), 1);
    chk("rst_table_ready", 32'(bus.TableReady), 0);
    chk("rst_jam_rst", 32'(bus.JamRST), 1);
    peek("rst_cost_5_3", 5, 3, 0);
    chk_sum("rst_checksum", 0);

    // Gapless load of idx values
    for (int i = 0; i < 64; i++) begin
      bus.LoadValid = 1'b1;
      bus.LoadData  = COST_W'(i);
      tick();
      if (i == 62) chk("gapless_not_ready_at_63", 32'(bus.TableReady), 0);
    end
    bus.LoadValid = 1'b0;
    chk("gapless_table_ready", 32'(bus.TableReady), 1);
    chk("gapless_load_ready", 32'(bus.LoadReady), 0);
    chk("gapless_jam_rst_held", 32'(bus.JamRST), 1);
    tick();
    chk("gapless_jam_rst_fall", 32'(bus.JamRST), 0);
    peek("gapless_cost_5_3", 5, 3, 43);
    peek("gapless_cost_7_7", 7, 7, 63);
    chk_sum("gapless_checksum", 2016);

    // LoadValid in READY is ignored
    for (int i = 0; i < 10; i++) begin
      bus.LoadValid = 1'b1;
      bus.LoadData  = COST_W'(99);
      tick();
    end
    bus.LoadValid = 1'b0;
    peek("ready_ignore_cost_0_0", 0, 0, 0);
    peek("ready_ignore_cost_1_1", 1, 1, 9);
    chk("ready_ignore_table_ready", 32'(bus.TableReady), 1);
    chk_sum("ready_ignore_checksum", 2016);

    // Reload: back to LOAD, contents kept, JamRST rises
    bus.Reload = 1'b1;
    tick();
    bus.Reload = 1'b0;
    chk("reload_jam_rst", 32'(bus.JamRST), 1);
    chk("reload_load_ready", 32'(bus.LoadReady), 1);
    chk("reload_table_ready", 32'(bus.TableReady), 0);
    peek("reload_keeps_cost_5_3", 5, 3, 43);
    chk_sum("reload_clears_checksum", 0);

    // Load with LoadValid on every other cycle
    for (int i = 0; i < 64; i++) begin
      bus.LoadValid = 1'b1;
      bus.LoadData  = COST_W'(i);
      tick();
      bus.LoadValid = 1'b0;
      if (i == 63) chk("gapped_table_ready", 32'(bus.TableReady), 1);
      else if (i == 62) chk("gapped_not_ready", 32'(bus.TableReady), 0);
      tick();
    end
    chk("gapped_jam_rst_released", 32'(bus.JamRST), 0);
    peek("gapped_cost_5_3", 5, 3, 43);
    peek("gapped_cost_2_6", 2, 6, 22);
    peek("gapped_cost_7_7", 7, 7, 63);
    chk_sum("gapped_checksum", 2016);

    // 30 entries, Reload (its data dropped), then 64 entries of 7
    bus.Reload = 1'b1;
    tick();
    bus.Reload = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.LoadValid = 1'b1;
      bus.LoadData  = COST_W'(100);
      tick();
      if (bus.JamRST !== 1'b1) chk("partial_jam_rst", 32'(bus.JamRST), 1);
    end
    bus.Reload    = 1'b1;
    bus.LoadData  = COST_W'(99);
    tick();
    bus.Reload = 1'b0;
    chk("midload_reload_jam_rst", 32'(bus.JamRST), 1);
    for (int i = 0; i < 64; i++) begin
      bus.LoadValid = 1'b1;
      bus.LoadData  = COST_W'(7);
      if (i == 40) peek("collide_old_value", 5, 0, 40);
      tick();
      if (i == 40) peek("collide_new_value", 5, 0, 7);
      if (i < 63 && bus.JamRST !== 1'b1) chk("sevens_jam_rst", 32'(bus.JamRST), 1);
      if (i == 62) chk("sevens_not_ready", 32'(bus.TableReady), 0);
    end
    bus.LoadValid = 1'b0;
    chk("sevens_table_ready", 32'(bus.TableReady), 1);
    chk("sevens_jam_rst_still_high", 32'(bus.JamRST), 1);
    peek("sevens_cost_7_7", 7, 7, 7);
    peek("sevens_cost_0_0", 0, 0, 7);
    chk_sum("sevens_checksum", 448);

    // Reload coincident with the idx=63 acceptance
    bus.Reload = 1'b1;
    tick();
    bus.Reload = 1'b0;
    for (int i = 0; i < 63; i++) begin
      bus.LoadValid = 1'b1;
      bus.LoadData  = COST_W'(1);
      tick();
    end
    bus.LoadData = COST_W'(5);
    bus.Reload   = 1'b1;
    tick();
    bus.Reload    = 1'b0;
    bus.LoadValid = 1'b0;
    chk("race_load_ready", 32'(bus.LoadReady), 1);
    chk("race_table_ready", 32'(bus.TableReady), 0);
    peek("race_entry_dropped", 7, 7, 7);
    peek("race_entry_62_kept", 7, 6, 1);
    bus.LoadValid = 1'b1;
    bus.LoadData  = COST_W'(9);
    tick();
    bus.LoadValid = 1'b0;
    peek("race_idx_zero", 0, 0, 9);
    peek("race_idx_one_untouched", 0, 1, 1);
    chk_sum("race_checksum", 9);

    // RST wins over Reload and LoadValid
    rst           = 1'b1;
    bus.Reload    = 1'b1;
    bus.LoadValid = 1'b1;
    bus.LoadData  = COST_W'(55);
    tick();
    rst           = 1'b0;
    bus.Reload    = 1'b0;
    bus.LoadValid = 1'b0;
    peek("rst_prio_cost_0_0", 0, 0, 0);
    peek("rst_prio_cost_7_6", 7, 6, 0);
    chk("rst_prio_jam_rst", 32'(bus.JamRST), 1);
    chk("rst_prio_load_ready", 32'(bus.LoadReady), 1);
    chk_sum("rst_prio_checksum", 0);
    bus.LoadValid = 1'b1;
    bus.LoadData  = COST_W'(3);
    tick();
    bus.LoadValid = 1'b0;
    peek("rst_prio_idx_zero", 0, 0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
